phy_tx_lane_sched: RTL and testbench
====================================

// Module: phy_tx_lane_sched
// PURPOSE
//  Byte-level scheduler that shares the single PHY TX serial lane between N_REQ byte sources.
//  - Runs in the clk_32f domain and tracks the 8-slot bit frame of the downstream parallel-to-serial stage.
//  - At each byte boundary, picks the next byte round-robin with a burst limit.
//  - After reset it sends a training run of idle bytes. When no source has data it presents the idle symbol.
// PARAMETERS
//  N_REQ        4      number of byte requesters (>=2)
//  MAX_BURST    4      max consecutive bytes one owner may send while others wait (>=1)
//  TRAIN_BYTES  4      idle bytes forced after reset before any grant (>=1)
//  IDLE_SYM     8'hBC  idle/comma byte driven on ser_data when ser_valid=0
// PORTS
//  clk_32f     in   1          bit-rate clock, all logic on rising edge
//  reset       in   1          synchronous, active-high
//  req_valid   in   N_REQ      requester i has a byte ready
//  req_data    in   8*N_REQ    requester i byte at [8i+7:8i], stable while req_valid[i]
//  req_pop     out  N_REQ      one-cycle pulse: requester i byte accepted, advance source
//  ser_data    out  8          byte to serializer, held 8 cycles, MSB sent first
//  ser_valid   out  1          1 = ser_data is payload; 0 = idle byte
//  ser_load    out  1          pulse in slot 7, i.e. the cycle before ser_data/ser_valid update
//  cur_owner   out  $clog2(N_REQ)  requester owning the byte now on ser_data (last owner when idle)
//  train_done  out  1          1 once the training run is complete; sticky until reset
// BEHAVIOUR
//  Reset: bit_cnt=0, state=S_TRAIN, ser_data=IDLE_SYM, ser_valid=0, req_pop=0, ser_load=0.
//   Also cleared: cur_owner=0, train_done=0, burst_cnt=0, train_cnt=0.
//  Reset mid-byte: the byte is truncated with no recovery. A byte counts as delivered at its req_pop.
//  Bit counter: bit_cnt 0..7, +1 every cycle, wraps 7->0. Boundary cycle = bit_cnt==7.
//  Decisions happen only in the boundary cycle. req_valid changes in slots 0..6 are ignored.
//  In the boundary cycle: ser_load=1; req_pop[g]=1 if a grant g is made.
//   Next edge: ser_data/ser_valid/cur_owner update; the serializer sees the new byte in slot 0.
//  Latency: req_valid sampled at boundary -> data on ser_data 1 cycle later; worst case 8 cycles from assert.
//  FSM (evaluated at boundary only):
//   S_TRAIN: emit IDLE_SYM, ser_valid=0, train_cnt++.
//    When train_cnt==TRAIN_BYTES-1 -> train_done=1, go to S_IDLE. No pops.
//   S_IDLE: if any req_valid -> grant by round-robin, go to S_DATA; else stay idle with IDLE_SYM and ser_valid=0.
//   S_DATA: ownership rules:
//    - keep owner if req_valid[owner] && (burst_cnt<MAX_BURST || no other valid).
//    - else grant next valid requester after owner (wrap N_REQ-1 -> 0) and set burst_cnt=1.
//    - if none valid -> S_IDLE, burst_cnt=0.
//  burst_cnt saturates at MAX_BURST. Keeping a sole requester never stalls.
//  After training the round-robin pointer starts so requester 0 has highest priority.
//  At most one req_pop bit is set per cycle. req_pop is never set outside the boundary cycle.
//  ser_data is byte-exact req_data of the granted requester, sampled in the boundary cycle.
// STRUCTURE
//  Shared package/header phy_tx_pkg, also used by the serializer and bench:
//   BYTE_W=8, IDLE_SYM, state encoding {S_TRAIN,S_IDLE,S_DATA}.
//  Sub-module rr_arbiter: combinational, inputs req mask + last owner, outputs one-hot grant + index + any.
//  Registers stay in phy_tx_lane_sched: bit_cnt, FSM, burst/train counters, output regs.
// TESTING (N_REQ=4, MAX_BURST=4, TRAIN_BYTES=4)
//  1 Reset 2 cycles, no requests:
//    ser_valid=0 and ser_data=8'hBC throughout.
//    ser_load every 8th cycle; train_done rises at the 4th boundary; zero pops.
//  2 After training, req 1 holds 8'hA5 then 8'h3C:
//    two pops spaced 8 cycles; ser_data=A5 for 8 cycles then 3C for 8 cycles, ser_valid=1, cur_owner=1.
//    Then idle 8'hBC with ser_valid=0.
//  3 All four valid continuously:
//    owner sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,... with exactly one pop per 8 cycles.
//  4 Req 2 owning, drops valid after 2 bytes, req 3 valid:
//    next byte from 3 with no idle gap; burst_cnt restarts at 1.
//  5 req_valid[0] asserted at bit_cnt=5 in S_IDLE:
//    pop only at the following bit_cnt=7; data on ser_data from next slot 0.
//  6 Reset asserted at bit_cnt=3 of a payload byte:
//    next cycle all outputs at reset values, no pop; training repeats in full.

Source files
------------

// File: rtl/phy_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_pkg
//  Description : Shared constants and types for the PHY TX byte lane
//                (scheduler, serializer and bench).
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_tx_pkg;

  // Width of one symbol on the serial lane.
  localparam int BYTE_W = 8;

  // Bit-slot counter covering one byte frame; slot 7 is the byte boundary.
  localparam int                SLOT_W    = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;

  // Comma/idle symbol driven whenever no payload is on the lane.
  localparam logic [BYTE_W-1:0] IDLE_SYM = 8'hBC;

  // Scheduler states.
  typedef enum logic [1:0] {
    S_TRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_DATA  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches the request mask
//                starting just after the last owner, wrapping N_REQ-1 -> 0,
//                and returns a one-hot grant, its index and an any flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int               w_pos;
  logic [IDX_W-1:0] w_cand;

  // Walk the requesters in rotating order and latch the first one found;
  // the last owner is visited last, so it only wins when nobody else asks.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_pos = int'(last_i) + k;
      if (w_pos >= N_REQ) begin
        w_pos = w_pos - N_REQ;
      end
      w_cand = IDX_W'(w_pos);
      if (!any_o && req_i[w_cand]) begin
        any_o           = 1'b1;
        idx_o           = w_cand;
        grant_o[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_lane_sched
//  Description : Shares the single PHY TX serial lane between N_REQ byte
//                sources. Tracks the 8-slot bit frame, sends a training run
//                of idle bytes after reset, then picks one byte per frame
//                round-robin with a burst limit. Idle symbol when no data.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_lane_sched #(
  parameter int                                N_REQ       = 4,
  parameter int                                MAX_BURST   = 4,
  parameter int                                TRAIN_BYTES = 4,
  parameter logic [phy_tx_pkg::BYTE_W-1:0]     IDLE_SYM    = phy_tx_pkg::IDLE_SYM
) (
  input  logic                                 clk_32f,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req_valid,
  input  logic [phy_tx_pkg::BYTE_W*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]                     req_pop,
  output logic [phy_tx_pkg::BYTE_W-1:0]        ser_data,
  output logic                                 ser_valid,
  output logic                                 ser_load,
  output logic [$clog2(N_REQ)-1:0]             cur_owner,
  output logic                                 train_done
);

  import phy_tx_pkg::*;

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int TRAIN_W = $clog2(TRAIN_BYTES + 1);

  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
  localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_BYTES - 1);
  localparam logic [TRAIN_W-1:0] TRAIN_ONE  = TRAIN_W'(1);
  // Pointer value that makes requester 0 the first candidate.
  localparam logic [IDX_W-1:0]   RR_START   = IDX_W'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [SLOT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  state_e             state_q,      state_d;
  logic [TRAIN_W-1:0] train_cnt_q,  train_cnt_d;
  logic               train_done_q, train_done_d;
  logic [BURST_W-1:0] burst_cnt_q,  burst_cnt_d;
  logic [BYTE_W-1:0]  ser_data_q,   ser_data_d;
  logic               ser_valid_q,  ser_valid_d;
  logic [IDX_W-1:0]   owner_q,      owner_d;
  logic [IDX_W-1:0]   rr_last_q,    rr_last_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_boundary;
  logic [BYTE_W-1:0]   w_req_bytes [N_REQ];
  logic [N_REQ-1:0]    w_arb_grant;
  logic [IDX_W-1:0]    w_arb_idx;
  logic                w_arb_any;
  logic [N_REQ-1:0]    w_owner_oh;
  logic                w_others_valid;
  logic                w_keep;
  logic [N_REQ-1:0]    w_pop;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  // Decisions are only taken in slot 7; reset suppresses load and pops.
  assign w_boundary     = (bit_cnt_q == LAST_SLOT) && !reset;
  assign w_owner_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign w_others_valid = |(req_valid & ~w_owner_oh);
  // The owner keeps the lane under its burst budget, or indefinitely when
  // nobody else is waiting.
  assign w_keep         = req_valid[owner_q] &&
                          ((burst_cnt_q < BURST_MAX) || !w_others_valid);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .last_i  (rr_last_q),
    .grant_o (w_arb_grant),
    .idx_o   (w_arb_idx),
    .any_o   (w_arb_any)
  );

  // Next-state and pop decision; everything holds except in the boundary slot.
  always_comb begin
    bit_cnt_d    = bit_cnt_q + 3'd1;
    state_d      = state_q;
    train_cnt_d  = train_cnt_q;
    train_done_d = train_done_q;
    burst_cnt_d  = burst_cnt_q;
    ser_data_d   = ser_data_q;
    ser_valid_d  = ser_valid_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    w_pop        = '0;

    if (w_boundary) begin
      case (state_q)
        S_TRAIN: begin
          ser_data_d  = IDLE_SYM;
          ser_valid_d = 1'b0;
          if (train_cnt_q == TRAIN_LAST) begin
            train_done_d = 1'b1;
            state_d      = S_IDLE;
            rr_last_d    = RR_START;
          end else begin
            train_cnt_d = train_cnt_q + TRAIN_ONE;
          end
        end

        S_IDLE: begin
          if (w_arb_any) begin
            w_pop       = w_arb_grant;
            ser_data_d  = w_req_bytes[w_arb_idx];
            ser_valid_d = 1'b1;
            owner_d     = w_arb_idx;
            rr_last_d   = w_arb_idx;
            burst_cnt_d = BURST_ONE;
            state_d     = S_DATA;
          end else begin
            ser_data_d  = IDLE_SYM;
            ser_valid_d = 1'b0;
          end
        end

        S_DATA: begin
          if (w_keep) begin
            w_pop[owner_q] = 1'b1;
            ser_data_d     = w_req_bytes[owner_q];
            ser_valid_d    = 1'b1;
            if (burst_cnt_q < BURST_MAX) begin
              burst_cnt_d = burst_cnt_q + BURST_ONE;
            end
          end else if (w_arb_any) begin
            w_pop       = w_arb_grant;
            ser_data_d  = w_req_bytes[w_arb_idx];
            ser_valid_d = 1'b1;
            owner_d     = w_arb_idx;
            rr_last_d   = w_arb_idx;
            burst_cnt_d = BURST_ONE;
          end else begin
            ser_data_d  = IDLE_SYM;
            ser_valid_d = 1'b0;
            burst_cnt_d = '0;
            state_d     = S_IDLE;
          end
        end

        default: begin
          state_d = S_TRAIN;
        end
      endcase
    end
  end

  // State register with synchronous reset; a byte in flight is simply dropped.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      state_q      <= S_TRAIN;
      train_cnt_q  <= '0;
      train_done_q <= 1'b0;
      burst_cnt_q  <= '0;
      ser_data_q   <= IDLE_SYM;
      ser_valid_q  <= 1'b0;
      owner_q      <= '0;
      rr_last_q    <= RR_START;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      state_q      <= state_d;
      train_cnt_q  <= train_cnt_d;
      train_done_q <= train_done_d;
      burst_cnt_q  <= burst_cnt_d;
      ser_data_q   <= ser_data_d;
      ser_valid_q  <= ser_valid_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
    end
  end

  assign req_pop    = w_pop;
  assign ser_load   = w_boundary;
  assign ser_data   = ser_data_q;
  assign ser_valid  = ser_valid_q;
  assign cur_owner  = owner_q;
  assign train_done = train_done_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_tx_lane_sched
//  Description : Directed self-checking bench for phy_tx_lane_sched
//                (N_REQ=4, MAX_BURST=4, TRAIN_BYTES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_tx_lane_sched;

  import phy_tx_pkg::*;

  logic        clk_32f;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_pop;
  logic [7:0]  ser_data;
  logic        ser_valid;
  logic        ser_load;
  logic [1:0]  cur_owner;
  logic        train_done;

  int n_chk;
  int n_bad;
  int byte_no;
  int slot_no;

  logic [7:0] dat [4];

  phy_tx_lane_sched #(
    .N_REQ       (4),
    .MAX_BURST   (4),
    .TRAIN_BYTES (4),
    .IDLE_SYM    (IDLE_SYM)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_pop    (req_pop),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_load   (ser_load),
    .cur_owner  (cur_owner),
    .train_done (train_done)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s byte=%0d slot=%0d got=%0h want=%0h", tag, byte_no, slot_no, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_32f);
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    req_data[8*i +: 8] = v;
  endtask

  // Checks one full byte frame starting at slot 0; returns at the next slot 0.
  task automatic byte_chk(input logic v, input logic [7:0] d, input int own,
                          input logic [3:0] pop, input logic td);
    for (int s = 0; s < 8; s++) begin
      slot_no = s;
      #1;
      chk("ser_valid",  32'(ser_valid),  32'(v));
      chk("ser_data",   32'(ser_data),   32'(d));
      chk("cur_owner",  32'(cur_owner),  32'(own));
      chk("train_done", 32'(train_done), 32'(td));
      chk("ser_load",   32'(ser_load),   (s == 7) ? 32'd1 : 32'd0);
      chk("req_pop",    32'(req_pop),    (s == 7) ? 32'(pop) : 32'd0);
      step();
    end
    byte_no++;
  endtask

  // Two-cycle reset entered at a negedge; deasserts at a negedge (slot 0).
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pop_now",  32'(req_pop),  32'd0);
    chk("rst_load_now", 32'(ser_load), 32'd0);
    step();
    #1;
    chk("rst_valid", 32'(ser_valid),  32'd0);
    chk("rst_data",  32'(ser_data),   32'(IDLE_SYM));
    chk("rst_owner", 32'(cur_owner),  32'd0);
    chk("rst_tdone", 32'(train_done), 32'd0);
    chk("rst_load",  32'(ser_load),   32'd0);
    chk("rst_pop",   32'(req_pop),    32'd0);
    step();
    reset   = 1'b0;
    byte_no = 0;
  endtask

  initial begin
    int own;
    logic [3:0] oh;
    n_chk     = 0;
    n_bad     = 0;
    byte_no   = 0;
    slot_no   = 0;
    req_valid = 4'b0000;
    req_data  = '0;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h44; dat[3] = 8'h88;

    do_reset();

    // Training: four idle bytes, train_done set by the 4th boundary.
    for (int b = 0; b < 4; b++) byte_chk(1'b0, IDLE_SYM, 0, 4'b0000, 1'b0);
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0000, 1'b1);

    // All four requesters valid: bursts of four, starting at requester 0.
    for (int i = 0; i < 4; i++) set_byte(i, dat[i]);
    req_valid = 4'b1111;
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0001, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      own = ((n - 1) / 4) % 4;
      oh  = 4'b0001 << ((n / 4) % 4);
      byte_chk(1'b1, dat[own], own, oh, 1'b1);
    end
    req_valid = 4'b0000;
    byte_chk(1'b1, dat[0], 0, 4'b0000, 1'b1);
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0000, 1'b1);

    // Requester 2 sends two bytes, then hands over to 3 without a gap;
    // 3 gets a fresh burst of four even with everyone else waiting.
    req_valid = 4'b0100;
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0100, 1'b1);
    byte_chk(1'b1, dat[2], 2, 4'b0100, 1'b1);
    req_valid = 4'b1000;
    byte_chk(1'b1, dat[2], 2, 4'b1000, 1'b1);
    req_valid = 4'b1111;
    byte_chk(1'b1, dat[3], 3, 4'b1000, 1'b1);
    byte_chk(1'b1, dat[3], 3, 4'b1000, 1'b1);
    byte_chk(1'b1, dat[3], 3, 4'b1000, 1'b1);
    byte_chk(1'b1, dat[3], 3, 4'b0001, 1'b1);
    req_valid = 4'b0000;
    byte_chk(1'b1, dat[0], 0, 4'b0000, 1'b1);
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0000, 1'b1);

    // Requester 1 sends A5 then 3C, then the lane returns to idle.
    set_byte(1, 8'hA5);
    req_valid = 4'b0010;
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0010, 1'b1);
    set_byte(1, 8'h3C);
    byte_chk(1'b1, 8'hA5, 1, 4'b0010, 1'b1);
    req_valid = 4'b0000;
    byte_chk(1'b1, 8'h3C, 1, 4'b0000, 1'b1);
    byte_chk(1'b0, IDLE_SYM, 1, 4'b0000, 1'b1);

    // A sole requester is never throttled by the burst limit.
    set_byte(1, dat[1]);
    req_valid = 4'b0010;
    byte_chk(1'b0, IDLE_SYM, 1, 4'b0010, 1'b1);
    for (int b = 0; b < 5; b++) byte_chk(1'b1, dat[1], 1, 4'b0010, 1'b1);
    req_valid = 4'b0000;
    byte_chk(1'b1, dat[1], 1, 4'b0000, 1'b1);
    byte_chk(1'b0, IDLE_SYM, 1, 4'b0000, 1'b1);

    // Mid-frame request changes: only what is valid at slot 7 matters.
    set_byte(0, 8'h5A);
    for (int s = 0; s < 8; s++) begin
      slot_no = s;
      if (s == 2) req_valid = 4'b1000;
      if (s == 3) req_valid = 4'b0000;
      if (s == 5) req_valid = 4'b0001;
      #1;
      chk("late_pop",   32'(req_pop),   (s == 7) ? 32'h1 : 32'h0);
      chk("late_valid", 32'(ser_valid), 32'd0);
      step();
    end
    byte_no++;
    req_valid = 4'b0000;
    byte_chk(1'b1, 8'h5A, 0, 4'b0000, 1'b1);
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0000, 1'b1);

    // Reset in slot 3 of a payload byte: everything restarts with training.
    set_byte(2, 8'hC3);
    req_valid = 4'b0100;
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0100, 1'b1);
    for (int s = 0; s < 3; s++) begin
      slot_no = s;
      #1;
      chk("pre_rst_data", 32'(ser_data), 32'hC3);
      step();
    end
    slot_no = 3;
    do_reset();
    for (int b = 0; b < 4; b++) byte_chk(1'b0, IDLE_SYM, 0, 4'b0000, 1'b0);
    byte_chk(1'b0, IDLE_SYM, 0, 4'b0100, 1'b1);
    req_valid = 4'b0000;
    byte_chk(1'b1, 8'hC3, 2, 4'b0000, 1'b1);
    byte_chk(1'b0, IDLE_SYM, 2, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
